// File: rtl/ni_param.sv
// rtl/ni_param.sv - NoC network interface: flit deserialiser to request FIFO, response FIFO to flit serialiser
// Define NI_PARITY_EN to add even flit parity, bad-packet dropping and a saturating drop counter.
module ni_param #(
  parameter int FLIT_W     = 16,
  parameter int BODY_FLITS = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [FLIT_W-1:0]                   i_flit,
  input  logic                                i_flit_valid,
  output logic                                i_flit_ready,
  output logic [FLIT_W-1:0]                   o_flit,
  output logic                                o_flit_valid,
  input  logic                                o_flit_ready,
  output logic [FLIT_W*(BODY_FLITS+2)-1:0]    fifo_wdata,
  output logic                                fifo_wreq,
  input  logic                                fifo_full,
  input  logic [FLIT_W*(BODY_FLITS+2)-1:0]    fifo_rdata,
  output logic                                fifo_rreq,
  input  logic                                fifo_empty,
  output logic                                rx_busy,
  output logic                                tx_busy
`ifdef NI_PARITY_EN
  ,
  input  logic                                i_flit_par,
  output logic                                o_flit_par,
  output logic [7:0]                          err_cnt
`endif
);

  localparam int TOTAL_FLITS = BODY_FLITS + 2;
  localparam int PKT_W       = FLIT_W * TOTAL_FLITS;
  localparam int IDX_W       = $clog2(TOTAL_FLITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_FLITS - 1);

  typedef enum logic {
    RX_COLLECT,
    RX_WRITE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND
  } tx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [PKT_W-1:0] rx_buf_q, rx_buf_d;

  tx_state_t        tx_state_q, tx_state_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [PKT_W-1:0] tx_buf_q, tx_buf_d;

`ifdef NI_PARITY_EN
  logic       rx_bad_q, rx_bad_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       flit_bad;

  assign flit_bad = ^{i_flit, i_flit_par};
`endif

  // Ingress: collect flits into the packed buffer, then offer it to the request FIFO
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_buf_d     = rx_buf_q;
    i_flit_ready = 1'b0;
    fifo_wreq    = 1'b0;
`ifdef NI_PARITY_EN
    rx_bad_d     = rx_bad_q;
    err_cnt_d    = err_cnt_q;
`endif
    case (rx_state_q)
      RX_COLLECT: begin
        i_flit_ready = 1'b1;
        if (i_flit_valid) begin
          rx_buf_d[int'(rx_idx_q)*FLIT_W +: FLIT_W] = i_flit;
          if (rx_idx_q == LAST_IDX) begin
            rx_idx_d = '0;
`ifdef NI_PARITY_EN
            // A packet with any bad flit never reaches the FIFO
            rx_bad_d = 1'b0;
            if (rx_bad_q || flit_bad) begin
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end else begin
              rx_state_d = RX_WRITE;
            end
`else
            rx_state_d = RX_WRITE;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
`ifdef NI_PARITY_EN
            rx_bad_d = rx_bad_q | flit_bad;
`endif
          end
        end
      end
      RX_WRITE: begin
        fifo_wreq = !fifo_full;
        if (!fifo_full) begin
          rx_state_d = RX_COLLECT;
        end
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_q <= RX_COLLECT;
      rx_idx_q   <= '0;
      rx_buf_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_buf_q   <= rx_buf_d;
    end
  end

`ifdef NI_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_bad_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rx_bad_q  <= rx_bad_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt    = err_cnt_q;
  assign o_flit_par = ^o_flit;
`endif

  assign fifo_wdata = rx_buf_q;
  assign rx_busy    = (rx_state_q != RX_COLLECT) || (rx_idx_q != '0);

  // Egress: fetch one packet (read data arrives a cycle after the strobe), then serialise it
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_idx_d     = tx_idx_q;
    tx_buf_d     = tx_buf_q;
    fifo_rreq    = 1'b0;
    o_flit_valid = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_rreq  = 1'b1;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tx_buf_d   = fifo_rdata;
        tx_idx_d   = '0;
        tx_state_d = TX_SEND;
      end
      TX_SEND: begin
        o_flit_valid = 1'b1;
        if (o_flit_ready) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_buf_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_buf_q   <= tx_buf_d;
    end
  end

  // Buffer and index only change on TX_LOAD and accepted flits, so o_flit keeps its last value when idle
  assign o_flit  = tx_buf_q[int'(tx_idx_q)*FLIT_W +: FLIT_W];
  assign tx_busy = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_ni_param.sv
// tb/tb_ni_param.sv - scoreboard bench for ni_param with randomized ingress/egress traffic
// Parity scenarios are included when NI_PARITY_EN is defined.
module tb_ni_param;

  localparam int FLIT_W      = 16;
  localparam int BODY_FLITS  = 2;
  localparam int TOTAL_FLITS = BODY_FLITS + 2;
  localparam int PKT_W       = FLIT_W * TOTAL_FLITS;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [FLIT_W-1:0] i_flit = '0;
  logic              i_flit_valid = 1'b0;
  logic              i_flit_ready;
  logic [FLIT_W-1:0] o_flit;
  logic              o_flit_valid;
  logic              o_flit_ready = 1'b0;
  logic [PKT_W-1:0]  fifo_wdata;
  logic              fifo_wreq;
  logic              fifo_full = 1'b0;
  logic [PKT_W-1:0]  fifo_rdata = '0;
  logic              fifo_rreq;
  logic              fifo_empty = 1'b1;
  logic              rx_busy;
  logic              tx_busy;
`ifdef NI_PARITY_EN
  logic              i_flit_par = 1'b0;
  logic              o_flit_par;
  logic [7:0]        err_cnt;
`endif

  ni_param #(.FLIT_W(FLIT_W), .BODY_FLITS(BODY_FLITS)) dut (
    .clk(clk), .resetn(resetn),
    .i_flit(i_flit), .i_flit_valid(i_flit_valid), .i_flit_ready(i_flit_ready),
    .o_flit(o_flit), .o_flit_valid(o_flit_valid), .o_flit_ready(o_flit_ready),
    .fifo_wdata(fifo_wdata), .fifo_wreq(fifo_wreq), .fifo_full(fifo_full),
    .fifo_rdata(fifo_rdata), .fifo_rreq(fifo_rreq), .fifo_empty(fifo_empty),
    .rx_busy(rx_busy), .tx_busy(tx_busy)
`ifdef NI_PARITY_EN
    , .i_flit_par(i_flit_par), .o_flit_par(o_flit_par), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rreq = 0;
  int n_resp_pushed = 0;
  int exp_drops = 0;
  bit rnd_on = 1'b0;

  logic [PKT_W-1:0]  exp_wr_q[$];
  logic [FLIT_W-1:0] exp_fl_q[$];
  logic [PKT_W-1:0]  resp_q[$];
  logic [FLIT_W-1:0] rx_acc[$];
  bit                rx_bad = 1'b0;

  task automatic check(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: every TOTAL_FLITS accepted flits form one packet, flit k at bits k*FLIT_W
  task automatic send_flit(input logic [FLIT_W-1:0] f, input bit bad);
    bit ok = 1'b0;
    logic [PKT_W-1:0] p;
    i_flit = f;
`ifdef NI_PARITY_EN
    i_flit_par = (^f) ^ bad;
`endif
    i_flit_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (i_flit_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    i_flit_valid = 1'b0;
    if (!ok) fail_now("flit_accept_timeout");
    rx_acc.push_back(f);
    rx_bad = rx_bad | bad;
    if (rx_acc.size() == TOTAL_FLITS) begin
      p = '0;
      for (int k = 0; k < TOTAL_FLITS; k++) p[k*FLIT_W +: FLIT_W] = rx_acc[k];
`ifdef NI_PARITY_EN
      if (rx_bad) exp_drops++;
      else exp_wr_q.push_back(p);
`else
      exp_wr_q.push_back(p);
`endif
      rx_acc.delete();
      rx_bad = 1'b0;
    end
  endtask

  task automatic send_rand_pkt(input int bad_idx);
    for (int k = 0; k < TOTAL_FLITS; k++) send_flit(FLIT_W'($urandom), k == bad_idx);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (o_flit_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  // Response FIFO model: a read strobe pops a packet, data shows up one cycle later
  initial begin
    logic [PKT_W-1:0] pkt;
    bit got;
    forever begin
      @(negedge clk);
      got = 1'b0;
      if (resetn && fifo_rreq) begin
        n_rreq++;
        check("rreq_when_empty", fifo_empty, 0);
        if (resp_q.size() > 0) begin
          pkt = resp_q.pop_front();
          got = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (got) begin
        fifo_rdata = pkt;
        for (int k = 0; k < TOTAL_FLITS; k++) exp_fl_q.push_back(pkt[k*FLIT_W +: FLIT_W]);
      end
      fifo_empty = (resp_q.size() == 0);
    end
  end

  // Monitor: compares request-FIFO writes and egress flits against the scoreboard queues
  initial begin
    bit hold_pending = 1'b0;
    logic [FLIT_W-1:0] hold_flit = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_pending = 1'b0;
      end else begin
        if (fifo_wreq) begin
          check("wreq_ready_low", i_flit_ready, 0);
          if (exp_wr_q.size() == 0) fail_now("unexpected_wreq");
          else check("fifo_wdata", fifo_wdata, exp_wr_q.pop_front());
        end
        if (hold_pending) begin
          check("hold_valid", o_flit_valid, 1);
          check("hold_flit", o_flit, hold_flit);
          hold_pending = 1'b0;
        end
        if (o_flit_valid) begin
`ifdef NI_PARITY_EN
          check("o_flit_par", o_flit_par, ^o_flit);
`endif
          if (o_flit_ready) begin
            if (exp_fl_q.size() == 0) fail_now("unexpected_flit");
            else check("o_flit", o_flit, exp_fl_q.pop_front());
          end else begin
            hold_pending = 1'b1;
            hold_flit = o_flit;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rreq0;
    logic [PKT_W-1:0] pk;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cycles(5);
    @(negedge clk);
    check("rst_i_flit_ready", i_flit_ready, 1);
    check("rst_o_flit_valid", o_flit_valid, 0);
    check("rst_o_flit", o_flit, 0);
    check("rst_fifo_wreq", fifo_wreq, 0);
    check("rst_fifo_rreq", fifo_rreq, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_tx_busy", tx_busy, 0);
`ifdef NI_PARITY_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;

    // Back-to-back ingress packet, FIFO ready
    send_flit(16'h1111, 0);
    send_flit(16'h2222, 0);
    send_flit(16'h3333, 0);
    send_flit(16'h4444, 0);
    @(negedge clk);
    check("pkt1_wreq", fifo_wreq, 1);
    check("pkt1_ready_low", i_flit_ready, 0);
    check("pkt1_wdata", fifo_wdata, 64'h4444_3333_2222_1111);
    @(negedge clk);
    check("pkt1_wreq_done", fifo_wreq, 0);
    check("pkt1_ready_back", i_flit_ready, 1);
    @(posedge clk);
    #1;

    // Same packet, FIFO full for three cycles after the tail
    send_flit(16'h1111, 0);
    send_flit(16'h2222, 0);
    send_flit(16'h3333, 0);
    fifo_full = 1'b1;
    send_flit(16'h4444, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_wreq_low", fifo_wreq, 0);
      check("full_ready_low", i_flit_ready, 0);
      check("full_wdata_stable", fifo_wdata, 64'h4444_3333_2222_1111);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    @(negedge clk);
    check("full_release_wreq", fifo_wreq, 1);
    check("full_release_wdata", fifo_wdata, 64'h4444_3333_2222_1111);
    @(posedge clk);
    #1;

    // Egress packet with ready pattern 1,0,1,1,1
    rreq0 = n_rreq;
    o_flit_ready = 1'b1;
    resp_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
    n_resp_pushed++;
    wait_valid("egress_start_timeout");
    check("eg_flit0", o_flit, 16'hAAAA);
    @(posedge clk); #1; o_flit_ready = 1'b0;
    @(negedge clk); check("eg_flit1a", o_flit, 16'hBBBB);
    @(posedge clk); #1; o_flit_ready = 1'b1;
    @(negedge clk); check("eg_flit1b", o_flit, 16'hBBBB);
    @(negedge clk); check("eg_flit2", o_flit, 16'hCCCC);
    @(negedge clk); check("eg_flit3", o_flit, 16'hDDDD);
    @(negedge clk);
    check("eg_tx_busy_done", tx_busy, 0);
    check("eg_valid_done", o_flit_valid, 0);
    check("eg_flit_holds", o_flit, 16'hDDDD);
    check("eg_rreq_pulses", n_rreq - rreq0, 1);
    @(posedge clk);
    #1;

    // Randomized concurrent traffic with random back-pressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          fifo_full = ($urandom_range(0, 3) == 0);
          o_flit_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          send_rand_pkt(-1);
          cycles($urandom_range(0, 3));
        end
      end
      begin
        for (int p = 0; p < 8; p++) begin
          pk = {$urandom, $urandom};
          resp_q.push_back(pk);
          n_resp_pushed++;
          cycles($urandom_range(0, 8));
        end
      end
    join
    rnd_on = 1'b0;
    cycles(2);
    fifo_full = 1'b0;
    o_flit_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (exp_wr_q.size() == 0 && exp_fl_q.size() == 0 && resp_q.size() == 0 && !tx_busy) break;
      cycles(1);
    end
    check("rand_wr_drained", exp_wr_q.size(), 0);
    check("rand_fl_drained", exp_fl_q.size(), 0);

    // Reset in the middle of an ingress packet while egress is mid-packet
    o_flit_ready = 1'b1;
    resp_q.push_back(64'h9999_8888_7777_6666);
    n_resp_pushed++;
    wait_valid("rst_egress_timeout");
    @(posedge clk);
    #1;
    o_flit_ready = 1'b0;
    send_flit(16'h0A0A, 0);
    send_flit(16'h0B0B, 0);
    @(negedge clk);
    check("mid_rx_busy", rx_busy, 1);
    check("mid_tx_busy", tx_busy, 1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_fl_q.delete();
    rx_acc.delete();
    rx_bad = 1'b0;
    @(negedge clk);
    check("inrst_valid", o_flit_valid, 0);
    check("inrst_tx_busy", tx_busy, 0);
    check("inrst_rx_busy", rx_busy, 0);
    check("inrst_ready", i_flit_ready, 1);
    check("inrst_wreq", fifo_wreq, 0);
    cycles(2);
    resetn = 1'b1;
    o_flit_ready = 1'b1;
    cycles(6);
    check("post_rst_tx_idle", tx_busy, 0);
    send_flit(16'h5151, 0);
    send_flit(16'h5252, 0);
    send_flit(16'h5353, 0);
    send_flit(16'h5454, 0);
    cycles(3);
    check("post_rst_written", exp_wr_q.size(), 0);

`ifdef NI_PARITY_EN
    // Bad parity on the second flit drops the packet; the next good one is written
    send_rand_pkt(1);
    cycles(4);
    check("par_err_cnt_1", err_cnt, exp_drops);
    send_rand_pkt(-1);
    cycles(4);
    check("par_err_cnt_stays", err_cnt, exp_drops);
    check("par_good_written", exp_wr_q.size(), 0);
`endif

    cycles(4);
    check("final_wr_q_empty", exp_wr_q.size(), 0);
    check("final_fl_q_empty", exp_fl_q.size(), 0);
    check("final_rreq_count", n_rreq, n_resp_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
